// File: rtl/plab5_mcore_mem_req_arb_if.sv
// Signal bundle between the two network ports (p0/p1) and one memory bank port.
// slave = arbiter view, master = network/memory (environment) view.
interface plab5_mcore_mem_req_arb_if #(
    parameter int p_mem_opaque_nbits = 8,
    parameter int p_mem_addr_nbits   = 32,
    parameter int p_mem_data_nbits   = 32
);
    localparam int LenW = $clog2(p_mem_data_nbits / 8);
    localparam int RQC  = 3 + p_mem_opaque_nbits + p_mem_addr_nbits + LenW;
    localparam int RSC  = 3 + p_mem_opaque_nbits + LenW;
    localparam int D    = p_mem_data_nbits;

    logic [RQC-1:0] req_in_msg_control_p0;
    logic [D-1:0]   req_in_msg_data_p0;
    logic           req_in_domain_p0;
    logic           req_in_val_p0;
    logic           req_in_rdy_p0;
    logic [RQC-1:0] req_in_msg_control_p1;
    logic [D-1:0]   req_in_msg_data_p1;
    logic           req_in_domain_p1;
    logic           req_in_val_p1;
    logic           req_in_rdy_p1;

    logic [RQC-1:0] mem_req_msg_control;
    logic [D-1:0]   mem_req_msg_data;
    logic           mem_req_domain;
    logic           mem_req_val;
    logic           mem_req_rdy;

    logic [RSC-1:0] mem_resp_msg_control;
    logic [D-1:0]   mem_resp_msg_data;
    logic           mem_resp_val;
    logic           mem_resp_rdy;

    logic [RSC-1:0] resp_out_msg_control_p0;
    logic [D-1:0]   resp_out_msg_data_p0;
    logic           resp_out_domain_p0;
    logic           resp_out_val_p0;
    logic           resp_out_rdy_p0;
    logic [RSC-1:0] resp_out_msg_control_p1;
    logic [D-1:0]   resp_out_msg_data_p1;
    logic           resp_out_domain_p1;
    logic           resp_out_val_p1;
    logic           resp_out_rdy_p1;

    modport slave (
        input  req_in_msg_control_p0, req_in_msg_data_p0, req_in_domain_p0, req_in_val_p0,
        input  req_in_msg_control_p1, req_in_msg_data_p1, req_in_domain_p1, req_in_val_p1,
        output req_in_rdy_p0, req_in_rdy_p1,
        output mem_req_msg_control, mem_req_msg_data, mem_req_domain, mem_req_val,
        input  mem_req_rdy,
        input  mem_resp_msg_control, mem_resp_msg_data, mem_resp_val,
        output mem_resp_rdy,
        output resp_out_msg_control_p0, resp_out_msg_data_p0, resp_out_domain_p0, resp_out_val_p0,
        output resp_out_msg_control_p1, resp_out_msg_data_p1, resp_out_domain_p1, resp_out_val_p1,
        input  resp_out_rdy_p0, resp_out_rdy_p1
    );

    modport master (
        output req_in_msg_control_p0, req_in_msg_data_p0, req_in_domain_p0, req_in_val_p0,
        output req_in_msg_control_p1, req_in_msg_data_p1, req_in_domain_p1, req_in_val_p1,
        input  req_in_rdy_p0, req_in_rdy_p1,
        input  mem_req_msg_control, mem_req_msg_data, mem_req_domain, mem_req_val,
        output mem_req_rdy,
        output mem_resp_msg_control, mem_resp_msg_data, mem_resp_val,
        input  mem_resp_rdy,
        input  resp_out_msg_control_p0, resp_out_msg_data_p0, resp_out_domain_p0, resp_out_val_p0,
        input  resp_out_msg_control_p1, resp_out_msg_data_p1, resp_out_domain_p1, resp_out_val_p1,
        output resp_out_rdy_p0, resp_out_rdy_p1
    );
endinterface

// File: rtl/plab5_mcore_mem_req_arb.sv
// Round-robin merge of two network request ports onto one memory bank, with in-order response steering.
// Optional grant/stall counters: define PLAB5_MCORE_MEM_ARB_PERF_CNT_EN.
module plab5_mcore_mem_req_arb #(
    parameter int p_mem_opaque_nbits = 8,
    parameter int p_mem_addr_nbits   = 32,
    parameter int p_mem_data_nbits   = 32,
    parameter int p_max_inflight     = 4
) (
    input  logic clk,
    input  logic reset,
    plab5_mcore_mem_req_arb_if.slave bus
`ifdef PLAB5_MCORE_MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0] grant_cnt_p0,
    output logic [31:0] grant_cnt_p1,
    output logic [31:0] stall_cnt
`endif
);
    localparam int LenW = $clog2(p_mem_data_nbits / 8);
    localparam int RQC  = 3 + p_mem_opaque_nbits + p_mem_addr_nbits + LenW;
    localparam int RSC  = 3 + p_mem_opaque_nbits + LenW;
    localparam int D    = p_mem_data_nbits;
    localparam int PtrW = $clog2(p_max_inflight);
    localparam int CntW = PtrW + 1;

    logic           out_val_q, out_val_d;
    logic [RQC-1:0] out_ctl_q, out_ctl_d;
    logic [D-1:0]   out_data_q, out_data_d;
    logic           out_dom_q, out_dom_d;
    logic           rr_q, rr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic           route_port_q [p_max_inflight];
    logic           route_dom_q  [p_max_inflight];

    logic load_ok, can_accept, grant, accept, sel_dom;
    logic fifo_empty, head_port, head_dom, resp_rdy, resp_pop;

    // Grant follows the only valid port; on contention rr_q (0 = favour p0) decides.
    assign load_ok    = !out_val_q || bus.mem_req_rdy;
    assign can_accept = load_ok && (cnt_q < CntW'(p_max_inflight));
    assign grant      = (bus.req_in_val_p0 ^ bus.req_in_val_p1) ? bus.req_in_val_p1 : rr_q;
    assign accept     = can_accept && (grant ? bus.req_in_val_p1 : bus.req_in_val_p0);
    assign sel_dom    = grant ? bus.req_in_domain_p1 : bus.req_in_domain_p0;

    assign bus.req_in_rdy_p0       = can_accept && !grant;
    assign bus.req_in_rdy_p1       = can_accept && grant;
    assign bus.mem_req_val         = out_val_q;
    assign bus.mem_req_msg_control = out_ctl_q;
    assign bus.mem_req_msg_data    = out_data_q;
    assign bus.mem_req_domain      = out_dom_q;

    assign fifo_empty = (cnt_q == '0);
    assign head_port  = route_port_q[rd_ptr_q];
    assign head_dom   = route_dom_q[rd_ptr_q];

    always_comb begin
        bus.resp_out_val_p0         = 1'b0;
        bus.resp_out_msg_control_p0 = '0;
        bus.resp_out_msg_data_p0    = '0;
        bus.resp_out_domain_p0      = 1'b0;
        bus.resp_out_val_p1         = 1'b0;
        bus.resp_out_msg_control_p1 = '0;
        bus.resp_out_msg_data_p1    = '0;
        bus.resp_out_domain_p1      = 1'b0;
        resp_rdy                    = 1'b0;
        if (!fifo_empty) begin
            if (head_port) begin
                bus.resp_out_val_p1         = bus.mem_resp_val;
                bus.resp_out_msg_control_p1 = bus.mem_resp_msg_control;
                bus.resp_out_msg_data_p1    = bus.mem_resp_msg_data;
                bus.resp_out_domain_p1      = head_dom;
                resp_rdy                    = bus.resp_out_rdy_p1;
            end else begin
                bus.resp_out_val_p0         = bus.mem_resp_val;
                bus.resp_out_msg_control_p0 = bus.mem_resp_msg_control;
                bus.resp_out_msg_data_p0    = bus.mem_resp_msg_data;
                bus.resp_out_domain_p0      = head_dom;
                resp_rdy                    = bus.resp_out_rdy_p0;
            end
        end
    end

    assign bus.mem_resp_rdy = resp_rdy;
    assign resp_pop         = bus.mem_resp_val && resp_rdy;

    always_comb begin
        out_val_d  = out_val_q;
        out_ctl_d  = out_ctl_q;
        out_data_d = out_data_q;
        out_dom_d  = out_dom_q;
        rr_d       = rr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        if (accept) begin
            out_val_d  = 1'b1;
            out_ctl_d  = grant ? bus.req_in_msg_control_p1 : bus.req_in_msg_control_p0;
            out_data_d = grant ? bus.req_in_msg_data_p1 : bus.req_in_msg_data_p0;
            out_dom_d  = sel_dom;
            rr_d       = !grant;
            wr_ptr_d   = wr_ptr_q + PtrW'(1);
        end else if (bus.mem_req_rdy) begin
            out_val_d = 1'b0;
        end
        if (resp_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({accept, resp_pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_val_q  <= 1'b0;
            out_ctl_q  <= '0;
            out_data_q <= '0;
            out_dom_q  <= 1'b0;
            rr_q       <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            out_val_q  <= out_val_d;
            out_ctl_q  <= out_ctl_d;
            out_data_q <= out_data_d;
            out_dom_q  <= out_dom_d;
            rr_q       <= rr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Route entries are only meaningful below cnt_q, so the storage needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            route_port_q[wr_ptr_q] <= grant;
            route_dom_q[wr_ptr_q]  <= sel_dom;
        end
    end

`ifdef PLAB5_MCORE_MEM_ARB_PERF_CNT_EN
    logic [31:0] grant_cnt_p0_q, grant_cnt_p1_q, stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt_p0_q <= '0;
            grant_cnt_p1_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            if (accept && !grant) grant_cnt_p0_q <= grant_cnt_p0_q + 32'd1;
            if (accept && grant)  grant_cnt_p1_q <= grant_cnt_p1_q + 32'd1;
            if ((bus.req_in_val_p0 || bus.req_in_val_p1) && !accept)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign grant_cnt_p0 = grant_cnt_p0_q;
    assign grant_cnt_p1 = grant_cnt_p1_q;
    assign stall_cnt    = stall_cnt_q;
`endif
endmodule

// File: tb/tb_plab5_mcore_mem_req_arb.sv
// Directed scenarios followed by random traffic, each cycle checked against a queue-based model.
module tb_plab5_mcore_mem_req_arb;
    localparam int O    = 8;
    localparam int A    = 32;
    localparam int D    = 32;
    localparam int N    = 4;
    localparam int LenW = $clog2(D / 8);
    localparam int RQC  = 3 + O + A + LenW;
    localparam int RSC  = 3 + O + LenW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    plab5_mcore_mem_req_arb_if #(
        .p_mem_opaque_nbits(O), .p_mem_addr_nbits(A), .p_mem_data_nbits(D)
    ) bus ();

`ifdef PLAB5_MCORE_MEM_ARB_PERF_CNT_EN
    logic [31:0] gc0, gc1, sc;
`endif

    plab5_mcore_mem_req_arb #(
        .p_mem_opaque_nbits(O), .p_mem_addr_nbits(A), .p_mem_data_nbits(D), .p_max_inflight(N)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef PLAB5_MCORE_MEM_ARB_PERF_CNT_EN
        ,
        .grant_cnt_p0(gc0),
        .grant_cnt_p1(gc1),
        .stall_cnt(sc)
`endif
    );

    typedef struct {
        logic [RQC-1:0] ctl;
        logic [D-1:0]   data;
        logic           dom;
    } req_t;
    typedef struct {
        logic src;
        logic dom;
    } route_t;

    // Model: the output register as a 0/1-entry queue, outstanding routes as a queue.
    req_t   out_q[$];
    route_t route_q[$];
    logic   rr;
    logic   m_acc, m_gnt, m_pop;
    int     errors = 0;
    int     checks = 0;
    int unsigned m_gc0 = 0, m_gc1 = 0, m_sc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        logic load_ok, can, g, h, erdy;
        logic           ev [2];
        logic [RSC-1:0] ec [2];
        logic [D-1:0]   ed [2];
        logic           edm[2];
        #1;
        load_ok = (out_q.size() == 0) || bus.mem_req_rdy;
        can     = load_ok && (route_q.size() < N);
        if (bus.req_in_val_p0 != bus.req_in_val_p1) g = bus.req_in_val_p1;
        else g = rr;
        m_gnt = g;
        m_acc = can && (g ? bus.req_in_val_p1 : bus.req_in_val_p0);
        chk("req_in_rdy_p0", bus.req_in_rdy_p0, can && !g);
        chk("req_in_rdy_p1", bus.req_in_rdy_p1, can && g);
        chk("mem_req_val", bus.mem_req_val, out_q.size() != 0);
        if (out_q.size() != 0) begin
            chk("mem_req_ctl", bus.mem_req_msg_control, out_q[0].ctl);
            chk("mem_req_data", bus.mem_req_msg_data, out_q[0].data);
            chk("mem_req_dom", bus.mem_req_domain, out_q[0].dom);
        end
        for (int p = 0; p < 2; p++) begin
            ev[p] = 1'b0; ec[p] = '0; ed[p] = '0; edm[p] = 1'b0;
        end
        erdy = 1'b0;
        if (route_q.size() != 0) begin
            h      = route_q[0].src;
            ev[h]  = bus.mem_resp_val;
            ec[h]  = bus.mem_resp_msg_control;
            ed[h]  = bus.mem_resp_msg_data;
            edm[h] = route_q[0].dom;
            erdy   = h ? bus.resp_out_rdy_p1 : bus.resp_out_rdy_p0;
        end
        m_pop = erdy && bus.mem_resp_val;
        chk("mem_resp_rdy", bus.mem_resp_rdy, erdy);
        chk("resp_val_p0", bus.resp_out_val_p0, ev[0]);
        chk("resp_val_p1", bus.resp_out_val_p1, ev[1]);
        chk("resp_ctl_p0", bus.resp_out_msg_control_p0, ec[0]);
        chk("resp_ctl_p1", bus.resp_out_msg_control_p1, ec[1]);
        chk("resp_data_p0", bus.resp_out_msg_data_p0, ed[0]);
        chk("resp_data_p1", bus.resp_out_msg_data_p1, ed[1]);
        chk("resp_dom_p0", bus.resp_out_domain_p0, edm[0]);
        chk("resp_dom_p1", bus.resp_out_domain_p1, edm[1]);
`ifdef PLAB5_MCORE_MEM_ARB_PERF_CNT_EN
        chk("grant_cnt_p0", gc0, m_gc0);
        chk("grant_cnt_p1", gc1, m_gc1);
        chk("stall_cnt", sc, m_sc);
`endif
    endtask

    task automatic tick();
        req_t   r;
        route_t rt;
        @(posedge clk);
        if (reset) begin
            out_q.delete();
            route_q.delete();
            rr = 1'b0;
            m_gc0 = 0; m_gc1 = 0; m_sc = 0;
        end else begin
            if (m_pop) void'(route_q.pop_front());
            if ((bus.req_in_val_p0 || bus.req_in_val_p1) && !m_acc) m_sc++;
            if (m_acc) begin
                r.ctl  = m_gnt ? bus.req_in_msg_control_p1 : bus.req_in_msg_control_p0;
                r.data = m_gnt ? bus.req_in_msg_data_p1 : bus.req_in_msg_data_p0;
                r.dom  = m_gnt ? bus.req_in_domain_p1 : bus.req_in_domain_p0;
                out_q.delete();
                out_q.push_back(r);
                rt.src = m_gnt;
                rt.dom = r.dom;
                route_q.push_back(rt);
                rr = !m_gnt;
                if (m_gnt) m_gc1++; else m_gc0++;
            end else if (bus.mem_req_rdy) begin
                out_q.delete();
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [RQC-1:0] mk_req(input logic [7:0] opq, input logic [31:0] addr);
        return {3'd0, opq, addr, 2'd0};
    endfunction

    initial begin
        logic [63:0] rnd;
        logic [RQC-1:0] b0, b1;
        rr = 1'b0;
        reset = 1'b1;
        bus.req_in_val_p0 = 0; bus.req_in_val_p1 = 0;
        bus.req_in_msg_control_p0 = '0; bus.req_in_msg_control_p1 = '0;
        bus.req_in_msg_data_p0 = '0; bus.req_in_msg_data_p1 = '0;
        bus.req_in_domain_p0 = 0; bus.req_in_domain_p1 = 0;
        bus.mem_req_rdy = 0; bus.mem_resp_val = 0;
        bus.mem_resp_msg_control = '0; bus.mem_resp_msg_data = '0;
        bus.resp_out_rdy_p0 = 1; bus.resp_out_rdy_p1 = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state and empty-FIFO response hold
        bus.mem_resp_val = 1; bus.mem_resp_msg_data = 32'h1234;
        settle();
        chk("rst_mem_req_val", bus.mem_req_val, 1'b0);
        chk("rst_mem_req_ctl", bus.mem_req_msg_control, '0);
        chk("rst_mem_req_data", bus.mem_req_msg_data, '0);
        chk("empty_resp_rdy", bus.mem_resp_rdy, 1'b0);
        chk("empty_val_p0", bus.resp_out_val_p0, 1'b0);
        chk("empty_val_p1", bus.resp_out_val_p1, 1'b0);
        tick();
        bus.mem_resp_val = 0;

        // Single port load to 0x1000
        bus.mem_req_rdy = 1;
        bus.req_in_val_p0 = 1; bus.req_in_msg_control_p0 = mk_req(8'h11, 32'h1000);
        bus.req_in_msg_data_p0 = 32'h0; bus.req_in_domain_p0 = 0;
        settle();
        chk("single_rdy_p0", bus.req_in_rdy_p0, 1'b1);
        tick();
        bus.req_in_val_p0 = 0;
        settle();
        chk("single_mem_val", bus.mem_req_val, 1'b1);
        chk("single_mem_ctl", bus.mem_req_msg_control, mk_req(8'h11, 32'h1000));
        chk("single_mem_dom", bus.mem_req_domain, 1'b0);
        tick();
        bus.mem_resp_val = 1; bus.mem_resp_msg_control = 13'h0440;
        bus.mem_resp_msg_data = 32'h0000CAFE;
        settle();
        chk("single_resp_val_p0", bus.resp_out_val_p0, 1'b1);
        chk("single_resp_data_p0", bus.resp_out_msg_data_p0, 32'h0000CAFE);
        chk("single_resp_dom_p0", bus.resp_out_domain_p0, 1'b0);
        chk("single_resp_val_p1", bus.resp_out_val_p1, 1'b0);
        tick();
        bus.mem_resp_val = 0;

        // Contention after a reset pulse: p0,p1,p0,p1 then FIFO full
        reset = 1; settle(); tick(); reset = 0;
        bus.req_in_val_p0 = 1; bus.req_in_val_p1 = 1;
        bus.req_in_msg_control_p0 = mk_req(8'h20, 32'h2000);
        bus.req_in_msg_control_p1 = mk_req(8'h21, 32'h3000);
        bus.req_in_domain_p1 = 1;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("cont_rdy_p0", bus.req_in_rdy_p0, (i < 4) && (i % 2 == 0));
            chk("cont_rdy_p1", bus.req_in_rdy_p1, (i < 4) && (i % 2 == 1));
            tick();
        end
        bus.req_in_val_p0 = 0; bus.req_in_val_p1 = 0;
        bus.mem_resp_val = 1;
        for (int i = 0; i < 4; i++) begin
            bus.mem_resp_msg_data = 32'hD000 + i;
            settle();
            chk("cont_resp_p0", bus.resp_out_val_p0, i % 2 == 0);
            chk("cont_resp_p1", bus.resp_out_val_p1, i % 2 == 1);
            tick();
        end
        bus.mem_resp_val = 0;

        // Backpressure: register held while mem_req_rdy=0, then drain+accept
        b0 = mk_req(8'h30, 32'h4000); b1 = mk_req(8'h31, 32'h5000);
        bus.mem_req_rdy = 0;
        bus.req_in_val_p0 = 1; bus.req_in_msg_control_p0 = b0;
        settle(); chk("bp_first_rdy", bus.req_in_rdy_p0, 1'b1); tick();
        bus.req_in_val_p1 = 1; bus.req_in_msg_control_p1 = b1;
        bus.req_in_msg_control_p0 = mk_req(8'h32, 32'h6000);
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("bp_rdy_p0", bus.req_in_rdy_p0, 1'b0);
            chk("bp_rdy_p1", bus.req_in_rdy_p1, 1'b0);
            chk("bp_hold_ctl", bus.mem_req_msg_control, b0);
            tick();
        end
        bus.mem_req_rdy = 1;
        settle(); chk("bp_drain_rdy_p1", bus.req_in_rdy_p1, 1'b1); tick();
        bus.req_in_val_p0 = 0; bus.req_in_val_p1 = 0;
        settle(); chk("bp_next_ctl", bus.mem_req_msg_control, b1); tick();
        bus.mem_resp_val = 1;
        repeat (2) begin settle(); tick(); end
        bus.mem_resp_val = 0;

        // Ordering: p1(dom1), p0, p1; p1 response stalls first
        bus.req_in_val_p1 = 1; bus.req_in_domain_p1 = 1; settle(); tick();
        bus.req_in_val_p1 = 0; bus.req_in_val_p0 = 1; bus.req_in_domain_p0 = 0; settle(); tick();
        bus.req_in_val_p0 = 0; bus.req_in_val_p1 = 1; bus.req_in_domain_p1 = 0; settle(); tick();
        bus.req_in_val_p1 = 0;
        bus.mem_resp_val = 1; bus.mem_resp_msg_data = 32'hAAA1;
        bus.resp_out_rdy_p1 = 0;
        settle();
        chk("ord_stall_rdy", bus.mem_resp_rdy, 1'b0);
        chk("ord_r1_val_p1", bus.resp_out_val_p1, 1'b1);
        chk("ord_r1_dom_p1", bus.resp_out_domain_p1, 1'b1);
        tick();
        bus.resp_out_rdy_p1 = 1;
        settle(); chk("ord_r1_rdy", bus.mem_resp_rdy, 1'b1); tick();
        bus.mem_resp_msg_data = 32'hAAA2;
        settle();
        chk("ord_r2_val_p0", bus.resp_out_val_p0, 1'b1);
        chk("ord_r2_data_p0", bus.resp_out_msg_data_p0, 32'hAAA2);
        chk("ord_r2_val_p1", bus.resp_out_val_p1, 1'b0);
        tick();
        bus.mem_resp_msg_data = 32'hAAA3;
        settle();
        chk("ord_r3_val_p1", bus.resp_out_val_p1, 1'b1);
        chk("ord_r3_data_p1", bus.resp_out_msg_data_p1, 32'hAAA3);
        chk("ord_r3_dom_p1", bus.resp_out_domain_p1, 1'b0);
        tick();
        bus.mem_resp_val = 0;

        // Reset with three requests outstanding
        bus.req_in_val_p0 = 1; settle(); tick();
        bus.req_in_val_p0 = 0; bus.req_in_val_p1 = 1; settle(); tick();
        bus.req_in_val_p1 = 0; bus.req_in_val_p0 = 1; settle(); tick();
        bus.req_in_val_p0 = 0;
        reset = 1; settle(); tick(); reset = 0;
        bus.mem_resp_val = 1;
        bus.req_in_val_p0 = 1; bus.req_in_val_p1 = 1;
        settle();
        chk("mrst_mem_req_val", bus.mem_req_val, 1'b0);
        chk("mrst_resp_rdy", bus.mem_resp_rdy, 1'b0);
        chk("mrst_grant_p0", bus.req_in_rdy_p0, 1'b1);
        chk("mrst_grant_p1", bus.req_in_rdy_p1, 1'b0);
        tick();

        // Random traffic
        for (int c = 0; c < 800; c++) begin
            reset = ($urandom_range(63) == 0);
            bus.req_in_val_p0 = ($urandom_range(2) != 0);
            bus.req_in_val_p1 = ($urandom_range(2) != 0);
            rnd = {$urandom(), $urandom()}; bus.req_in_msg_control_p0 = rnd[RQC-1:0];
            rnd = {$urandom(), $urandom()}; bus.req_in_msg_control_p1 = rnd[RQC-1:0];
            bus.req_in_msg_data_p0 = $urandom(); bus.req_in_msg_data_p1 = $urandom();
            bus.req_in_domain_p0 = $urandom_range(1); bus.req_in_domain_p1 = $urandom_range(1);
            bus.mem_req_rdy = ($urandom_range(3) != 0);
            bus.mem_resp_val = $urandom_range(1);
            rnd = {$urandom(), $urandom()}; bus.mem_resp_msg_control = rnd[RSC-1:0];
            bus.mem_resp_msg_data = $urandom();
            bus.resp_out_rdy_p0 = ($urandom_range(3) != 0);
            bus.resp_out_rdy_p1 = ($urandom_range(3) != 0);
            settle();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
